univ_shift_reg: RTL and testbench

//  Parametrised universal shift register, successor to the fixed 4-bit SIPO register.

---
 rtl/usr_pkg.sv | 19 +
 rtl/univ_shift_reg_if.sv | 29 ++
 rtl/usr_cell.sv | 41 ++++
 rtl/univ_shift_reg.sv | 65 ++++++
 tb/tb_univ_shift_reg.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// Shared mode encodings and width helper for the universal shift register.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Ceiling log2, floored at 1 so a WIDTH of 2 still gets a 1-bit counter.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control, data and status bundle for univ_shift_reg; master drives controls, slave is the register.
interface univ_shift_reg_if
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = clog2(WIDTH)
);
  logic             clear;
  logic             en;
  logic [1:0]       mode;
  logic             ser_in_lsb;
  logic             ser_in_msb;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] par_out;
  logic             ser_out_msb;
  logic             ser_out_lsb;
  logic             frame_done;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output clear, en, mode, ser_in_lsb, ser_in_msb, par_in,
    input  par_out, ser_out_msb, ser_out_lsb, frame_done, bit_cnt
  );

  modport slave (
    input  clear, en, mode, ser_in_lsb, ser_in_msb, par_in,
    output par_out, ser_out_msb, ser_out_lsb, frame_done, bit_cnt
  );
endinterface

// File: rtl/usr_cell.sv
// One register bit: 4:1 mux (hold / shift-left source / shift-right source / load) into a flop.
// Reset and clear both return the bit to its reset value, independent of en.
module usr_cell
  import usr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_shl_src,
  input  logic       i_shr_src,
  input  logic       i_par,
  output logic       o_q
);

  logic r_q;
  logic w_d;

  always_comb begin
    w_d = r_q;
    if (i_en) begin
      case (i_mode)
        MODE_SHL:  w_d = i_shl_src;
        MODE_SHR:  w_d = i_shr_src;
        MODE_LOAD: w_d = i_par;
        default:   w_d = r_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) r_q <= RST_BIT;
    else                  r_q <= w_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold/SHL/SHR/load) with a frame counter that pulses frame_done
// in the cycle par_out shows every WIDTH-th shifted word.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  univ_shift_reg_if.slave   bus
);

  localparam int CNT_W = clog2(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_shl_src;
  logic [WIDTH-1:0] w_shr_src;
  logic             w_shift;
  logic             w_load;
  logic             w_wrap;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // Neighbour taps: bit i takes bit i-1 on SHL and bit i+1 on SHR.
  assign w_shl_src = {w_q[WIDTH-2:0], bus.ser_in_lsb};
  assign w_shr_src = {bus.ser_in_msb, w_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_cell #(.RST_BIT(RESET_VAL[i])) u_cell (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (bus.clear),
      .i_en      (bus.en),
      .i_mode    (bus.mode),
      .i_shl_src (w_shl_src[i]),
      .i_shr_src (w_shr_src[i]),
      .i_par     (bus.par_in[i]),
      .o_q       (w_q[i])
    );
  end

  assign w_shift = bus.en && ((bus.mode == MODE_SHL) || (bus.mode == MODE_SHR));
  assign w_load  = bus.en && (bus.mode == MODE_LOAD);
  assign w_wrap  = w_shift && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_wrap;
      if (w_load)       r_cnt <= '0;
      else if (w_wrap)  r_cnt <= '0;
      else if (w_shift) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.par_out     = w_q;
  assign bus.ser_out_msb = w_q[WIDTH-1];
  assign bus.ser_out_lsb = w_q[0];
  assign bus.frame_done  = r_done;
  assign bus.bit_cnt     = r_cnt;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: WIDTH=4 with RESET_VAL 0 and a twin with RESET_VAL 4'h9.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int W  = 4;
  localparam int CW = 2;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   n_pulse;

  univ_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus_a ();
  univ_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus_b ();

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(4'h0)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  univ_shift_reg #(.WIDTH(W), .RESET_VAL(4'h9)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // The twin sees exactly the same controls.
  assign bus_b.clear      = bus_a.clear;
  assign bus_b.en         = bus_a.en;
  assign bus_b.mode       = bus_a.mode;
  assign bus_b.ser_in_lsb = bus_a.ser_in_lsb;
  assign bus_b.ser_in_msb = bus_a.ser_in_msb;
  assign bus_b.par_in     = bus_a.par_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one set of inputs across one rising edge; outputs are sampled 1ns after it.
  task automatic cyc(input logic en, input logic [1:0] mode, input logic sil,
                     input logic sim, input logic [W-1:0] par);
    bus_a.en         = en;
    bus_a.mode       = mode;
    bus_a.ser_in_lsb = sil;
    bus_a.ser_in_msb = sim;
    bus_a.par_in     = par;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [W-1:0] po, input logic [CW-1:0] cnt,
                           input logic fd);
    chk({tag, ".par_out"}, 32'(bus_a.par_out), 32'(po));
    chk({tag, ".bit_cnt"}, 32'(bus_a.bit_cnt), 32'(cnt));
    chk({tag, ".frame_done"}, 32'(bus_a.frame_done), 32'(fd));
  endtask

  initial begin
    logic [W-1:0] exp_po [4];
    logic         sil_v  [4];
    logic         lsb_v  [4];
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus_a.clear = 1'b0;
    bus_a.en = 1'b0;
    bus_a.mode = MODE_HOLD;
    bus_a.ser_in_lsb = 1'b0;
    bus_a.ser_in_msb = 1'b0;
    bus_a.par_in = '0;

    // 1: reset two cycles, then SHL 1,0,1,1
    cyc(1'b0, MODE_HOLD, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, MODE_HOLD, 1'b0, 1'b0, 4'h0);
    chk_state("t1.rst", 4'h0, 2'd0, 1'b0);
    chk("t1.rst_b.par_out", 32'(bus_b.par_out), 32'h9);
    reset = 1'b0;
    sil_v  = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_po = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, MODE_SHL, sil_v[i], 1'b0, 4'h0);
      chk_state($sformatf("t1.shl%0d", i), exp_po[i], CW'((i + 1) % 4), (i == 3));
    end
    cyc(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'h0);
    chk_state("t1.hold", 4'b1011, 2'd0, 1'b0);

    // 2: LOAD A then SHR x4 with zero fill; LSB-first out
    cyc(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'hA);
    chk_state("t2.load", 4'hA, 2'd0, 1'b0);
    chk("t2.ser_out_msb", 32'(bus_a.ser_out_msb), 32'd1);
    lsb_v = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2.ser_out_lsb%0d", i), 32'(bus_a.ser_out_lsb), 32'(lsb_v[i]));
      cyc(1'b1, MODE_SHR, 1'b0, 1'b0, 4'h0);
      chk($sformatf("t2.fd%0d", i), 32'(bus_a.frame_done), 32'(i == 3));
    end
    chk_state("t2.end", 4'h0, 2'd0, 1'b1);

    // 3: 2x SHL, en low 3 cycles with SHL on mode, 2x SHL
    cyc(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
    cyc(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
    chk_state("t3.two", 4'b0011, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, MODE_SHL, 1'b1, 1'b0, 4'h0);
      chk_state($sformatf("t3.en0_%0d", i), 4'b0011, 2'd2, 1'b0);
    end
    cyc(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
    chk_state("t3.s3", 4'b0111, 2'd3, 1'b0);
    cyc(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
    chk_state("t3.s4", 4'b1111, 2'd0, 1'b1);

    // 4: 3x SHL, LOAD 5 aborts the frame, then one full frame
    for (int i = 0; i < 3; i++) cyc(1'b1, MODE_SHL, 1'b0, 1'b0, 4'h0);
    chk_state("t4.three", 4'b1000, 2'd3, 1'b0);
    cyc(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'h5);
    chk_state("t4.load", 4'h5, 2'd0, 1'b0);
    exp_po = '{4'b1010, 4'b0100, 4'b1000, 4'b0000};
    n_pulse = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, MODE_SHL, 1'b0, 1'b0, 4'h0);
      if (bus_a.frame_done) n_pulse++;
      chk_state($sformatf("t4.shl%0d", i), exp_po[i], CW'((i + 1) % 4), (i == 3));
    end
    chk("t4.pulses", 32'(n_pulse), 32'd1);

    // 5: clear beats LOAD; reset mid-frame behaves the same
    cyc(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
    chk_state("t5.pre", 4'b0001, 2'd1, 1'b0);
    bus_a.clear = 1'b1;
    cyc(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'hF);
    bus_a.clear = 1'b0;
    chk_state("t5.clear", 4'h0, 2'd0, 1'b0);
    chk("t5.clear_b.par_out", 32'(bus_b.par_out), 32'h9);
    cyc(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
    cyc(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
    chk_state("t5.mid", 4'b0011, 2'd2, 1'b0);
    reset = 1'b1;
    cyc(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
    reset = 1'b0;
    chk_state("t5.reset", 4'h0, 2'd0, 1'b0);
    chk("t5.reset_b.par_out", 32'(bus_b.par_out), 32'h9);

    // 6: eight back-to-back SHL; pulses at shift 4 and 8 only
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, MODE_SHL, 1'b1, 1'b0, 4'h0);
      chk($sformatf("t6.fd%0d", i), 32'(bus_a.frame_done), 32'((i == 3) || (i == 7)));
      if (i == 0) chk("t6.b_first", 32'(bus_b.par_out), 32'b0011);
    end
    chk_state("t6.end", 4'hF, 2'd0, 1'b1);
    chk("t6.b_end", 32'(bus_b.par_out), 32'hF);
    cyc(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'h0);
    chk_state("t6.hold", 4'hF, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
